// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, ALUOp/funct encodings and issue FSM states
package alu_pkg;
  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;
  localparam logic [3:0] CTRL_NAND = 4'b1101;
  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_RTYPE = 2'b10;
  localparam logic [1:0] AOP_SLT   = 2'b11;
  localparam logic [5:0] FN_ADD    = 6'b100000;
  localparam logic [5:0] FN_SUB    = 6'b100010;
  localparam logic [5:0] FN_AND    = 6'b100100;
  localparam logic [5:0] FN_OR     = 6'b100101;
  localparam logic [5:0] FN_NOR    = 6'b100111;
  localparam logic [5:0] FN_SLT    = 6'b101010;
  localparam logic [5:0] FN_NAND   = 6'b111101;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: combinational ALUOp/funct to ALU control decode
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] ctrl,
  output logic       valid,
  output logic       ovf_en
);
  logic [3:0] fn_ctrl;
  logic       fn_ok;
  always_comb begin
    fn_ctrl = CTRL_ADD;
    fn_ok = 1'b1;
    case (funct)
      FN_ADD:  fn_ctrl = CTRL_ADD;
      FN_SUB:  fn_ctrl = CTRL_SUB;
      FN_AND:  fn_ctrl = CTRL_AND;
      FN_OR:   fn_ctrl = CTRL_OR;
      FN_NOR:  fn_ctrl = CTRL_NOR;
      FN_SLT:  fn_ctrl = CTRL_SLT;
      FN_NAND: fn_ctrl = CTRL_NAND;
      default: fn_ok = 1'b0;
    endcase
    ctrl = aluop == AOP_RTYPE ? fn_ctrl : aluop == AOP_SUB ? CTRL_SUB : aluop == AOP_SLT ? CTRL_SLT : CTRL_ADD;
    valid = aluop != AOP_RTYPE || fn_ok;
    ovf_en = ctrl == CTRL_ADD || ctrl == CTRL_SUB;
  end
endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: valid/ready front end that issues one op to the ALU and returns its captured result
module alu_issue_unit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_aluop,
  input  logic [5:0]  in_funct,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  output logic        alu_rst_n,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_overflow,
  output logic        out_err,
  output logic [15:0] op_count,
  output logic [7:0]  err_count
);
  state_e     state, state_nx;
  logic [3:0] dec_ctrl;
  logic       dec_valid, dec_ovf_en, ovf_en_q, acc, done;
  alu_ctrl_dec u_dec (
    .aluop  (in_aluop),
    .funct  (in_funct),
    .ctrl   (dec_ctrl),
    .valid  (dec_valid),
    .ovf_en (dec_ovf_en)
  );
  // alu_rst_n doubles as a "reset released" flag so in_ready stays low during reset
  assign in_ready = state == IDLE && alu_rst_n;
  assign out_valid = state == RESP;
  assign acc = in_valid && in_ready;
  assign done = out_valid && out_ready;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = acc ? (dec_valid ? EXEC : RESP) : IDLE;
      EXEC:    state_nx = RESP;
      RESP:    state_nx = done ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      alu_rst_n <= 1'b0;
      alu_src1 <= '0;
      alu_src2 <= '0;
      alu_ctrl <= CTRL_ADD;
      ovf_en_q <= 1'b0;
      out_result <= '0;
      out_zero <= 1'b0;
      out_overflow <= 1'b0;
      out_err <= 1'b0;
      op_count <= '0;
      err_count <= '0;
    end else begin
      state <= state_nx;
      alu_rst_n <= 1'b1;
      if (acc && dec_valid) begin
        alu_src1 <= in_src1;
        alu_src2 <= in_src2;
        alu_ctrl <= dec_ctrl;
        ovf_en_q <= dec_ovf_en;
      end
      if (acc && !dec_valid) begin
        out_err <= 1'b1;
        out_result <= '0;
        out_zero <= 1'b0;
        out_overflow <= 1'b0;
      end
      if (state == EXEC) begin
        out_result <= alu_result;
        out_zero <= alu_zero;
        out_overflow <= alu_overflow && ovf_en_q;
        out_err <= 1'b0;
      end
      if (done) begin
        op_count <= op_count + 16'd1;
        if (out_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: randomized self-checking bench with a behavioural ALU stub and reference model
module tb_alu_issue_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [1:0]  in_aluop = '0;
  logic [5:0]  in_funct = '0;
  logic [31:0] in_src1 = '0, in_src2 = '0;
  logic        alu_rst_n;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero, alu_overflow;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero, out_overflow, out_err;
  logic [15:0] op_count;
  logic [7:0]  err_count;
  int          n_cmp = 0, n_bad = 0;
  logic [15:0] exp_ops = '0;
  logic [7:0]  exp_errs = '0;
  logic [3:0]  exp_ctrl = 4'b0010;
  logic [31:0] exp_s1 = '0, exp_s2 = '0;
  typedef struct {
    logic [31:0] r;
    logic        z, v, e;
    logic [3:0]  c;
  } exp_t;
  alu_issue_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_funct(in_funct), .in_src1(in_src1), .in_src2(in_src2),
    .alu_rst_n(alu_rst_n), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_overflow(out_overflow), .out_err(out_err),
    .op_count(op_count), .err_count(err_count)
  );
  always #5 clk = ~clk;
  // stand-in ALU; reports overflow=1 on logic ops so the unit's masking is exercised
  always_comb begin
    alu_result = 32'hDEADBEEF;
    alu_overflow = 1'b1;
    case (alu_ctrl)
      4'b0000: alu_result = alu_src1 & alu_src2;
      4'b0001: alu_result = alu_src1 | alu_src2;
      4'b0010: begin
        alu_result = alu_src1 + alu_src2;
        alu_overflow = alu_src1[31] == alu_src2[31] && alu_result[31] != alu_src1[31];
      end
      4'b0110: begin
        alu_result = alu_src1 - alu_src2;
        alu_overflow = alu_src1[31] != alu_src2[31] && alu_result[31] != alu_src1[31];
      end
      4'b0111: alu_result = {31'b0, $signed(alu_src1) < $signed(alu_src2)};
      4'b1100: alu_result = ~(alu_src1 | alu_src2);
      4'b1101: alu_result = ~(alu_src1 & alu_src2);
      default: alu_result = 32'hDEADBEEF;
    endcase
    alu_zero = alu_result == 32'd0;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    exp_t  x;
    string k;
    longint s, d;
    k = op == 2'd0 ? "add" : op == 2'd1 ? "sub" : op == 2'd3 ? "slt" :
        fn == 6'h20 ? "add" : fn == 6'h22 ? "sub" : fn == 6'h24 ? "and" : fn == 6'h25 ? "or" :
        fn == 6'h27 ? "nor" : fn == 6'h2A ? "slt" : fn == 6'h3D ? "nand" : "err";
    s = longint'($signed(a)) + longint'($signed(b));
    d = longint'($signed(a)) - longint'($signed(b));
    x.r = '0; x.v = 1'b0; x.e = 1'b0; x.c = 4'b0010;
    case (k)
      "add":  begin x.r = a + b; x.v = s != longint'($signed(x.r)); x.c = 4'b0010; end
      "sub":  begin x.r = a - b; x.v = d != longint'($signed(x.r)); x.c = 4'b0110; end
      "and":  begin x.r = a & b; x.c = 4'b0000; end
      "or":   begin x.r = a | b; x.c = 4'b0001; end
      "nor":  begin x.r = ~(a | b); x.c = 4'b1100; end
      "nand": begin x.r = ~(a & b); x.c = 4'b1101; end
      "slt":  begin x.r = $signed(a) < $signed(b) ? 32'd1 : 32'd0; x.c = 4'b0111; end
      default: x.e = 1'b1;
    endcase
    x.z = !x.e && x.r == 32'd0;
    return x;
  endfunction
  function automatic logic [31:0] pick();
    logic [31:0] c[5] = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h1};
    return $urandom_range(0, 3) == 0 ? c[$urandom_range(0, 4)] : $urandom;
  endfunction
  task automatic junk();
    in_valid = 1'($urandom);
    in_aluop = 2'($urandom);
    in_funct = 6'($urandom);
    in_src1 = $urandom;
    in_src2 = $urandom;
  endtask
  task automatic check_reset();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_out_ovf", out_overflow, 0);
    check("rst_alu_src1", alu_src1, 0);
    check("rst_alu_src2", alu_src2, 0);
    check("rst_alu_ctrl", alu_ctrl, 4'b0010);
    check("rst_alu_rst_n", alu_rst_n, 0);
    check("rst_op_count", op_count, 0);
    check("rst_err_count", err_count, 0);
  endtask
  task automatic run_op(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b, input int hold);
    exp_t e;
    e = model(op, fn, a, b);
    check("idle_ready", in_ready, 1);
    in_valid = 1'b1; in_aluop = op; in_funct = fn; in_src1 = a; in_src2 = b;
    out_ready = hold == 0;
    @(negedge clk);
    junk();
    check("busy_ready", in_ready, 0);
    if (!e.e) begin
      exp_ctrl = e.c; exp_s1 = a; exp_s2 = b;
      check("exec_valid", out_valid, 0);
      @(negedge clk);
      junk();
    end
    check("alu_ctrl", alu_ctrl, exp_ctrl);
    check("alu_src1", alu_src1, exp_s1);
    check("alu_src2", alu_src2, exp_s2);
    for (int i = 0; i <= hold; i++) begin
      check("resp_valid", out_valid, 1);
      check("resp_ready", in_ready, 0);
      check("out_result", out_result, e.r);
      check("out_zero", out_zero, e.z);
      check("out_overflow", out_overflow, e.v);
      check("out_err", out_err, e.e);
      if (i == hold) out_ready = 1'b1;
      else begin
        @(negedge clk);
        junk();
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    exp_ops++;
    if (e.e && exp_errs != 8'hFF) exp_errs++;
    check("done_valid", out_valid, 0);
    check("op_count", op_count, exp_ops);
    check("err_count", err_count, exp_errs);
  endtask
  initial begin
    logic [5:0] fns[7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3D};
    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_alu_rst_n", alu_rst_n, 1);
    run_op(2'b00, 6'h00, 32'h7FFFFFFF, 32'h00000001, 0);
    run_op(2'b01, 6'h00, 32'h00001234, 32'h00001234, 2);
    run_op(2'b10, 6'h2A, 32'hFFFFFFFB, 32'h00000007, 1);
    run_op(2'b10, 6'h2A, 32'h00000007, 32'hFFFFFFFB, 0);
    run_op(2'b10, 6'h27, 32'h0F0F0F0F, 32'h00FF00FF, 0);
    run_op(2'b10, 6'h08, 32'h12345678, 32'h9ABCDEF0, 0);
    run_op(2'b10, 6'h20, $urandom, $urandom, 5);
    in_valid = 1'b1; in_aluop = 2'b00; in_funct = '0; in_src1 = $urandom; in_src2 = $urandom;
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    out_ready = 1'b0;
    exp_ops = '0; exp_errs = '0; exp_ctrl = 4'b0010; exp_s1 = '0; exp_s2 = '0;
    @(negedge clk);
    check("abort_valid", out_valid, 0);
    check("abort_ready", in_ready, 1);
    check("abort_op_count", op_count, 0);
    for (int n = 0; n < 300; n++) begin
      logic [1:0] op;
      logic [5:0] fn;
      op = 2'($urandom);
      fn = $urandom_range(0, 3) == 0 ? 6'($urandom) : fns[$urandom_range(0, 6)];
      run_op(op, fn, pick(), pick(), $urandom_range(0, 3));
    end
    for (int n = 0; n < 270; n++) run_op(2'b10, 6'h3F, $urandom, $urandom, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Initiator-side front end for the 32-bit ripple ALU. It accepts one operation per valid/ready handshake and decodes the MIPS-style ALUOp/funct pair into the ALU's 4-bit control code. It then drives the registered operands and control to the combinational ALU, captures result/zero/overflow one cycle later, and returns them on a valid/ready response channel. It sits between the decode stage and the ALU instance in the datapath.

## Interface
- No parameters; data width fixed at 32, control width fixed at 4.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_aluop  in  2  00 add, 01 sub, 10 R-type (use funct), 11 slt
- in_funct  in  6  R-type function field
- in_src1, in_src2  in  32  operands
- alu_rst_n  out  1  drives ALU rst_n
- alu_src1, alu_src2  out  32  ALU operands (registered)
- alu_ctrl  out  4  ALU control (registered)
- alu_result  in  32  from ALU
- alu_zero, alu_overflow  in  1  from ALU
- out_valid  out  1  response valid
- out_ready  in  1  response consumed when out_valid & out_ready
- out_result  out  32  captured result
- out_zero  out  1  captured zero
- out_overflow  out  1  overflow, masked to 0 unless op is add/sub
- out_err  out  1  unsupported funct; result fields are 0
- op_count  out  16  completed responses, wraps 0xFFFF→0
- err_count  out  8  error responses, saturates at 0xFF

## Operation
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, NAND 1101.
- Funct decode under ALUOp 10:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT, 111101 NAND.
  - Any other funct is an error.
- FSM states IDLE, EXEC, RESP.
- IDLE: in_ready=1.
  - Handshake with a valid decode: latch operands and alu_ctrl, then go to EXEC.
  - Handshake with an invalid decode: set out_err=1 and result fields to 0, leave ALU drive unchanged, then go to RESP.
- EXEC: in_ready=0. The ALU settles combinationally. At the end of the cycle, capture alu_result, alu_zero and alu_overflow (overflow ANDed with op∈{ADD,SUB}), clear out_err, then go to RESP.
- RESP: out_valid=1, with out_* held stable until out_ready.
  - On the handshake: op_count+1; err_count+1 (saturating) if out_err; then go to IDLE.
- alu_src*/alu_ctrl hold their last issued values outside EXEC.
- alu_rst_n is a register: 0 while rst_n=0, 1 on the first cycle after reset release.

## Timing
- Reset values (rst_n=0 sampled at a clock edge):
  - state IDLE.
  - in_ready=0 during reset, 1 on the first cycle after reset.
  - out_valid=0, out_err=0, out_result=0, out_zero=0, out_overflow=0.
  - alu_src1/2=0, alu_ctrl=0010, alu_rst_n=0, op_count=0, err_count=0.
- Latency for valid ops: request accepted at edge N → out_valid high in cycle N+2.
- Latency for error ops: out_valid high in cycle N+1.
- Throughput: at most one op per 3 cycles (2 for errors), since in_ready is high only in IDLE.
- No combinational path from in_* to out_* or from out_ready to in_ready.
- out_ready already high when RESP is entered: response completes in that cycle; IDLE and in_ready follow in the next cycle.
- in_valid may drop or change without penalty while in_ready=0; it is sampled only in IDLE.
- Reset asserted in EXEC or RESP aborts the in-flight op. No response is emitted and the counters are cleared.

## Structure
- Package alu_pkg: ALU control code constants, ALUOp encodings, funct constants, and the FSM state typedef (2-bit IDLE/EXEC/RESP).
- Sub-module alu_ctrl_dec: combinational (aluop, funct) → (ctrl[3:0], valid, ovf_en).
- The ALU is not instanced inside this block; the parent connects the alu_* ports.

## Test plan
- ADD via ALUOp 00: 0x7FFFFFFF + 0x00000001 → out_result 0x80000000, out_overflow=1, out_zero=0, out_valid in cycle N+2.
- SUB via ALUOp 01: 0x1234 − 0x1234 → out_result 0, out_zero=1, out_overflow=0.
- R-type SLT (funct 101010): src1 0xFFFFFFFB (−5), src2 7 → out_result 1. Swapped operands → 0.
- R-type NOR (funct 100111): 0x0F0F0F0F, 0x00FF00FF → out_result 0xF000F000, out_overflow masked to 0.
- Unsupported funct 001000: → out_err=1, out_result 0, response in cycle N+1, alu_ctrl unchanged, err_count=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles → out_* stable and in_ready=0 throughout.
  - Then pulse rst_n low during the next EXEC → no response, op_count=0, all outputs at reset values.
